// File: rtl/spi_dac_quad_sched_pkg.sv
// Shared constants, FSM state type and frame layout for the quad LTC2624 SPI scheduler.
package dac_sched_pkg;

    localparam logic [3:0] WRITE_UPD  = 4'b0011;
    localparam logic [3:0] WRITE      = 4'b0000;
    localparam logic [3:0] UPD        = 4'b0001;
    localparam logic [3:0] ADDR_ALL   = 4'b1111;
    localparam int         FRAME_BITS = 24;
    localparam int         NUM_CH     = 4;
    localparam int         SAMPLE_W   = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_END   = 3'd3,
        ST_GAP   = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [3:0]          cmd;
        logic [3:0]          addr;
        logic [SAMPLE_W-1:0] data;
        logic [3:0]          pad;
    } dac_frame_t;

    function automatic dac_frame_t build_frame(input logic [3:0] cmd, input logic [3:0] addr,
                                               input logic [SAMPLE_W-1:0] data);
        dac_frame_t f;
        f.cmd  = cmd;
        f.addr = addr;
        f.data = data;
        f.pad  = 4'h0;
        return f;
    endfunction

endpackage

// File: rtl/spi_dac_quad_sched_rr_arbiter4.sv
// Combinational 4-way round-robin grant: first pending channel after the last-served one.
module rr_arbiter4 (
    input  logic [3:0] pending,
    input  logic [1:0] last,
    output logic       grant_valid,
    output logic [1:0] grant_idx
);
    logic [1:0] cand;

    // Walk from farthest to nearest so the nearest pending channel wins.
    always_comb begin
        grant_valid = |pending;
        grant_idx   = last;
        cand        = last;
        for (int k = 4; k >= 1; k--) begin
            cand = last + 2'(k);
            if (pending[cand]) grant_idx = cand;
        end
    end
endmodule

// File: rtl/spi_dac_quad_sched.sv
// Quad-channel LTC2624 write scheduler: per-channel hold registers, round-robin SPI frames.
// Optional DAC_SCHED_SIMUL_UPDATE_EN: write-only channel frames followed by one update-all frame.
module spi_dac_quad_sched
    import dac_sched_pkg::*;
#(
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [47:0] ch_data,
    input  logic [3:0]  ch_valid,
    output logic [3:0]  ch_ready,
    output logic        spi_sck,
    output logic        spi_sdo,
    output logic        spi_dac_cs,
    output logic        frame_done,
    output logic [1:0]  frame_ch
);
`ifdef DAC_SCHED_SIMUL_UPDATE_EN
    localparam logic [3:0] CH_CMD = WRITE;
`else
    localparam logic [3:0] CH_CMD = WRITE_UPD;
`endif

    logic [NUM_CH-1:0]                pending;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  hold;
    sched_state_t                     state;
    logic [1:0]                       last, cur_ch;
    logic [FRAME_BITS-1:0]            shreg;
    logic [4:0]                       bit_cnt;
    logic                             phase;
    logic [11:0]                      gap_cnt;
    logic                             grant_valid;
    logic [1:0]                       grant_idx;
    logic                             is_upd;
    logic                             start_upd;
    dac_frame_t                       frame;

    assign ch_ready = ~pending;

    rr_arbiter4 u_arb (
        .pending     (pending),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

`ifdef DAC_SCHED_SIMUL_UPDATE_EN
    logic upd_frame, dirty;
    assign is_upd    = upd_frame;
    assign start_upd = dirty;

    always_ff @(posedge clk) begin
        if (reset) begin
            upd_frame <= 1'b0;
            dirty     <= 1'b0;
        end else if (state == ST_IDLE) begin
            upd_frame <= !grant_valid && dirty;
        end else if (state == ST_LOAD) begin
            dirty <= !upd_frame;
        end
    end
`else
    assign is_upd    = 1'b0;
    assign start_upd = 1'b0;
`endif

    always_comb begin
        frame = build_frame(CH_CMD, {2'b00, cur_ch}, hold[cur_ch]);
        if (is_upd) frame = build_frame(UPD, ADDR_ALL, '0);
    end

    // Ready is low while pending, so accept and LOAD-clear never collide on one channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            hold    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_valid[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    hold[i]    <= ch_data[SAMPLE_W*i +: SAMPLE_W];
                end else if (state == ST_LOAD && !is_upd && cur_ch == 2'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Outputs are registered on the edge entering a state, so they describe the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last       <= 2'd3;
            cur_ch     <= 2'd0;
            shreg      <= '0;
            bit_cnt    <= '0;
            phase      <= 1'b0;
            gap_cnt    <= '0;
            spi_dac_cs <= 1'b1;
            spi_sck    <= 1'b0;
            spi_sdo    <= 1'b0;
            frame_done <= 1'b0;
            frame_ch   <= 2'd0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        cur_ch     <= grant_idx;
                        spi_dac_cs <= 1'b0;
                        state      <= ST_LOAD;
                    end else if (start_upd) begin
                        cur_ch     <= 2'd3;
                        spi_dac_cs <= 1'b0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shreg   <= frame;
                    spi_sdo <= frame[FRAME_BITS-1];
                    bit_cnt <= '0;
                    phase   <= 1'b0;
                    if (!is_upd) last <= cur_ch;
                    state   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!phase) begin
                        phase   <= 1'b1;
                        spi_sck <= 1'b1;
                    end else begin
                        phase   <= 1'b0;
                        spi_sck <= 1'b0;
                        shreg   <= shreg << 1;
                        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                            spi_dac_cs <= 1'b1;
                            spi_sdo    <= 1'b0;
                            frame_done <= 1'b1;
                            frame_ch   <= cur_ch;
                            state      <= ST_END;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            spi_sdo <= shreg[FRAME_BITS-2];
                        end
                    end
                end
                // END counts as the first gap clock.
                ST_END: begin
                    if (GAP_CYCLES <= 1) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= 12'(GAP_CYCLES - 2);
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) state <= ST_IDLE;
                    else               gap_cnt <= gap_cnt - 12'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_dac_quad_sched.sv
// Scoreboard bench for spi_dac_quad_sched: GAP_CYCLES=16 instance (a) and GAP_CYCLES=0 instance (b).
`timescale 1ns/1ps
module tb_spi_dac_quad_sched;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] ch_data_a = '0, ch_data_b = '0;
    logic [3:0]  ch_valid_a = '0, ch_valid_b = '0;
    logic [3:0]  ch_ready_a, ch_ready_b;
    logic        sck_a, sdo_a, cs_a, fd_a, sck_b, sdo_b, cs_b, fd_b;
    logic [1:0]  fch_a, fch_b;

    always #5 clk = ~clk;

    spi_dac_quad_sched #(.GAP_CYCLES(16)) dut_a (
        .clk(clk), .reset(reset), .ch_data(ch_data_a), .ch_valid(ch_valid_a), .ch_ready(ch_ready_a),
        .spi_sck(sck_a), .spi_sdo(sdo_a), .spi_dac_cs(cs_a), .frame_done(fd_a), .frame_ch(fch_a));

    spi_dac_quad_sched #(.GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .ch_data(ch_data_b), .ch_valid(ch_valid_b), .ch_ready(ch_ready_b),
        .spi_sck(sck_b), .spi_sdo(sdo_b), .spi_dac_cs(cs_b), .frame_done(fd_b), .frame_ch(fch_b));

    int          n_cmp = 0, n_bad = 0, cyc = 0;
    logic [25:0] exp_a[$], exp_b[$];   // {frame_ch, 24-bit word}
    int          fall_a[$], hi_b[$];
    logic [23:0] sh[2];
    int          nb[2], hi_run[2];
    logic        sck_q[2], cs_q[2];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic mon_step(input int u);
        logic [25:0] e;
        logic        has, cs, sck, sdo, fd;
        logic [1:0]  fch;
        cs  = (u == 0) ? cs_a  : cs_b;
        sck = (u == 0) ? sck_a : sck_b;
        sdo = (u == 0) ? sdo_a : sdo_b;
        fd  = (u == 0) ? fd_a  : fd_b;
        fch = (u == 0) ? fch_a : fch_b;
        if (reset) begin
            nb[u] = 0; sck_q[u] = 1'b0; cs_q[u] = 1'b1; hi_run[u] = 0;
            return;
        end
        if (!cs && sck && !sck_q[u]) begin
            sh[u] = {sh[u][22:0], sdo};
            nb[u]++;
        end
        if (cs_q[u] && !cs) begin
            if (u == 0) fall_a.push_back(cyc);
            else        hi_b.push_back(hi_run[u]);
        end
        hi_run[u] = cs ? hi_run[u] + 1 : 0;
        if (fd) begin
            has = (u == 0) ? (exp_a.size() > 0) : (exp_b.size() > 0);
            n_cmp++;
            if (!has) begin
                n_bad++;
                $display("FAIL frame_u%0d unexpected frame: got word %h ch %0d", u, sh[u], fch);
            end else begin
                if (u == 0) e = exp_a.pop_front();
                else        e = exp_b.pop_front();
                if ({fch, sh[u]} !== e || nb[u] != 24) begin
                    n_bad++;
                    $display("FAIL frame_u%0d got word %h ch %0d bits %0d, want word %h ch %0d bits 24",
                             u, sh[u], fch, nb[u], e[23:0], e[25:24]);
                end
            end
            nb[u] = 0;
        end
        sck_q[u] = sck;
        cs_q[u]  = cs;
    endtask

    initial forever begin
        @(negedge clk);
        for (int u = 0; u < 2; u++) mon_step(u);
    end

    task automatic apply_reset();
        reset = 1'b1;
        ch_valid_a = '0; ch_valid_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_a.delete(); exp_b.delete(); fall_a.delete(); hi_b.delete();
        @(negedge clk);
    endtask

    // Drive at a negedge, accepted on the following posedge; returns at the next negedge.
    task automatic offer(input int u, input logic [3:0] m, input logic [47:0] d);
        if (u == 0) begin ch_valid_a = m; ch_data_a = d; end
        else        begin ch_valid_b = m; ch_data_b = d; end
        @(negedge clk);
        ch_valid_a = '0; ch_valid_b = '0;
    endtask

    task automatic wait_drain(input int u, input int budget);
        int left;
        for (int i = 0; i < budget; i++) begin
            left = (u == 0) ? exp_a.size() : exp_b.size();
            if (left == 0) break;
            @(negedge clk);
        end
        left = (u == 0) ? exp_a.size() : exp_b.size();
        n_cmp++;
        if (left != 0) begin
            n_bad++;
            $display("FAIL drain_u%0d timeout: %0d frames outstanding, want 0", u, left);
            if (u == 0) exp_a.delete(); else exp_b.delete();
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cs_a, sck_a, sdo_a, fd_a} !== 4'b1000) begin
            n_bad++; $display("FAIL reset_spi got cs/sck/sdo/fd %b want 1000", {cs_a, sck_a, sdo_a, fd_a});
        end
        n_cmp++;
        if (fch_a !== 2'd0) begin n_bad++; $display("FAIL reset_frame_ch got %0d want 0", fch_a); end
        n_cmp++;
        if (ch_ready_a !== 4'hF) begin n_bad++; $display("FAIL reset_ready got %b want 1111", ch_ready_a); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cs_a !== 1'b1 || cs_b !== 1'b1) begin
            n_bad++; $display("FAIL idle_cs got a=%b b=%b want 1 1", cs_a, cs_b);
        end
    endtask

    task automatic test_single();
        apply_reset();
        exp_a.push_back({2'd0, 24'h30ABC0});
        offer(0, 4'b0001, 48'h000000000ABC);
        n_cmp++;
        if (cs_a !== 1'b1 || ch_ready_a !== 4'b1110) begin
            n_bad++; $display("FAIL single_idle got cs %b ready %b want cs 1 ready 1110", cs_a, ch_ready_a);
        end
        @(negedge clk);
        n_cmp++;
        if (cs_a !== 1'b0) begin n_bad++; $display("FAIL single_latency got cs %b want 0", cs_a); end
        wait_drain(0, 200);
    endtask

    task automatic test_all_four();
        apply_reset();
        exp_a.push_back({2'd0, 24'h301110});
        exp_a.push_back({2'd1, 24'h312220});
        exp_a.push_back({2'd2, 24'h323330});
        exp_a.push_back({2'd3, 24'h334440});
        offer(0, 4'b1111, {12'h444, 12'h333, 12'h222, 12'h111});
        wait_drain(0, 400);
        n_cmp++;
        if (fall_a.size() != 4) begin
            n_bad++; $display("FAIL all4_cs_falls got %0d want 4", fall_a.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                n_cmp++;
                if (fall_a[i] - fall_a[i-1] != 66) begin
                    n_bad++; $display("FAIL all4_period%0d got %0d want 66", i, fall_a[i] - fall_a[i-1]);
                end
            end
        end
    endtask

    task automatic test_overwrite();
        apply_reset();
        exp_a.push_back({2'd1, 24'h315550});
        exp_a.push_back({2'd1, 24'h316660});
        offer(0, 4'b0010, 48'h000000555000);
        n_cmp++;
        if (ch_ready_a[1] !== 1'b0) begin n_bad++; $display("FAIL ovw_ready_idle got %b want 0", ch_ready_a[1]); end
        @(negedge clk);
        n_cmp++;
        if (cs_a !== 1'b0 || ch_ready_a[1] !== 1'b0) begin
            n_bad++; $display("FAIL ovw_load got cs %b ready %b want 0 0", cs_a, ch_ready_a[1]);
        end
        @(negedge clk);
        n_cmp++;
        if (ch_ready_a[1] !== 1'b1) begin n_bad++; $display("FAIL ovw_ready_shift got %b want 1", ch_ready_a[1]); end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (cs_a !== 1'b0) begin n_bad++; $display("FAIL ovw_in_shift got cs %b want 0", cs_a); end
        offer(0, 4'b0010, 48'h000000666000);
        n_cmp++;
        if (ch_ready_a[1] !== 1'b0) begin n_bad++; $display("FAIL ovw_ready_2nd got %b want 0", ch_ready_a[1]); end
        wait_drain(0, 400);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        offer(0, 4'b0001, 48'h000000000123);
        @(negedge clk);
        repeat (21) @(negedge clk);
        n_cmp++;
        if (nb[0] != 10 || cs_a !== 1'b0) begin
            n_bad++; $display("FAIL midrst_position got bits %0d cs %b want 10 0", nb[0], cs_a);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({cs_a, sck_a, sdo_a, fd_a} !== 4'b1000) begin
            n_bad++; $display("FAIL midrst_outputs got cs/sck/sdo/fd %b want 1000", {cs_a, sck_a, sdo_a, fd_a});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (cs_a !== 1'b1 || ch_ready_a !== 4'hF) begin
            n_bad++; $display("FAIL midrst_after got cs %b ready %b want 1 1111", cs_a, ch_ready_a);
        end
        exp_a.push_back({2'd0, 24'h307890});
        offer(0, 4'b0001, 48'h000000000789);
        wait_drain(0, 200);
    endtask

    task automatic test_gap0();
        apply_reset();
        exp_b.push_back({2'd2, 24'h322AB0});
        exp_b.push_back({2'd3, 24'h333CD0});
        offer(1, 4'b1100, {12'h3CD, 12'h2AB, 24'h0});
        wait_drain(1, 300);
        n_cmp++;
        if (hi_b.size() != 2) begin
            n_bad++; $display("FAIL gap0_cs_falls got %0d want 2", hi_b.size());
        end else begin
            n_cmp++;
            if (hi_b[1] != 2) begin n_bad++; $display("FAIL gap0_cs_high got %0d clks want 2", hi_b[1]); end
        end
    endtask

    task automatic test_simul_update();
        apply_reset();
        exp_a.push_back({2'd0, 24'h000F00});
        exp_a.push_back({2'd3, 24'h03F000});
        exp_a.push_back({2'd3, 24'h1F0000});
        offer(0, 4'b1001, {12'hF00, 24'h0, 12'h0F0});
        wait_drain(0, 500);
        repeat (200) @(negedge clk);
        n_cmp++;
        if (fall_a.size() != 3 || cs_a !== 1'b1) begin
            n_bad++; $display("FAIL simul_frames got %0d frames cs %b want 3 1", fall_a.size(), cs_a);
        end
    endtask

    initial begin
        test_reset();
`ifdef DAC_SCHED_SIMUL_UPDATE_EN
        test_simul_update();
`else
        test_single();
        test_all_four();
        test_overwrite();
        test_reset_mid();
        test_gap0();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_dac_quad_sched.md
# spi_dac_quad_sched

Four-channel scheduler for the Spartan-3E starter-kit quad SPI DAC (LTC2624). It accepts 12-bit samples from up to four independent synth voices or CV sources, holds the latest sample per DAC channel and serialises writes round-robin onto a single SPI link. It replaces the single-channel fixed-address DAC driver wherever more than one DAC output is in use, and sits between voice outputs and the board SPI pins.

## Interface
- `GAP_CYCLES`, 16: idle clocks with CS high between frames (0..4095).
- `clk`  in  1  system clock.
- `reset`  in  1  reset reset, synchronous, active-high; clock clk.
- `ch_data`  in  48  channel i sample at bits [12i+11:12i].
- `ch_valid`  in  4  per-channel sample offer.
- `ch_ready`  out  4  per-channel accept; equals `~pending[i]`.
- `spi_sck`  out  1  SPI clock, clk/2 while shifting, otherwise low.
- `spi_sdo`  out  1  serial data, MSB first.
- `spi_dac_cs`  out  1  DAC chip select, active low.
- `frame_done`  out  1  one-cycle pulse on the cycle CS returns high.
- `frame_ch`  out  2  channel of the most recent frame; valid with `frame_done`.

## Operation
- Per channel: 12-bit hold register and `pending` flag. A handshake (`ch_valid[i] & ch_ready[i]`) loads the hold register and sets `pending[i]`.
- FSM states: IDLE, LOAD, SHIFT, END, GAP.
- IDLE: if any `pending` is set, the round-robin arbiter grants the first pending channel after `last` (the last-served channel). Go to LOAD. Otherwise stay in IDLE.
- LOAD (1 clk): build shift register {cmd, addr, data, 4'h0}, with cmd=4'b0011 and addr={2'b00, ch}. Clear `pending[ch]`, update `last`, drive CS low. Go to SHIFT.
- SHIFT (48 clks, 24 bits × 2 phases): in phase 0, sck is low and sdo is set to the current MSB. In phase 1, sck is high. The register shifts left after phase 1.
- END (1 clk): CS high, sck low, `frame_done`=1. Go to GAP.
- GAP: hold for `GAP_CYCLES` clocks, then go to IDLE. If `GAP_CYCLES`=0, go directly to IDLE.
- Bit counter is 5 bits; no wrap is permitted beyond 23.

## Timing
- Reset values: `spi_dac_cs`=1, `spi_sck`=0, `spi_sdo`=0, `frame_done`=0, `frame_ch`=0. All `pending` cleared, `last`=3 so channel 0 is served first, FSM in IDLE. Reset mid-frame aborts the frame immediately.
- All SPI outputs are registered. SDO is stable for at least 1 clk before and after each rising sck.
- Latency from an accepted sample to CS low, with the FSM idle: 2 clks (IDLE sample, then LOAD).
- Frame period under continuous backlog is 50 + `GAP_CYCLES` clks.
- Arbitration uses registered `pending`. A sample accepted on the cycle IDLE evaluates is not seen until the next evaluation.
- Because `pending[ch]` clears in LOAD, a new sample for a channel can be accepted while that channel's frame is shifting. The frame in flight keeps the old data.
- `ch_ready` drops the cycle after acceptance. Hold data is never overwritten while pending.

## Configuration
- `DAC_SCHED_SIMUL_UPDATE_EN` defined:
  - Channel frames use cmd 4'b0000 (write input register only).
  - A `dirty` flag sets on each channel frame.
  - In IDLE with no pending channel and `dirty`=1, an update-all frame is issued: cmd 4'b0001, addr 4'b1111, data 0, giving 24'h1F0000. It uses the same LOAD/SHIFT/END/GAP sequence, clears `dirty`, and reports `frame_ch`=3.
  - All DAC outputs therefore change together.
- Undefined: cmd 4'b0011 (write and update the addressed channel); no update-all frames are issued.

## Structure
- Package `dac_sched_pkg`:
  - cmd constants (WRITE_UPD=4'b0011, WRITE=4'b0000, UPD=4'b0001).
  - `ADDR_ALL`=4'b1111.
  - `FRAME_BITS`=24.
  - FSM state enum.
- Sub-module `rr_arbiter4`: combinational 4-way round-robin grant from `pending` and `last`, outputting `grant_valid` and a 2-bit `grant_idx`.

## Test plan
- Reset, then ch0 offers 12'hABC -> CS low 2 clks later, 24 sck rising edges carrying 24'h30ABC0, then `frame_done` with `frame_ch`=0.
- All four channels offer in the same cycle (0x111, 0x222, 0x333, 0x444) -> frames ordered ch0..ch3: 24'h301110, 24'h312220, 24'h323330, 24'h334440. CS-low edges are 66 clks apart with `GAP_CYCLES`=16.
- Ch1 offers 0x555, then offers 0x666 during its SHIFT -> the first frame carries 0x555 and a second ch1 frame carries 0x666. `ch_ready[1]` is low only between acceptance and the following LOAD.
- `reset` asserted at SHIFT bit 10 -> the next clk shows CS=1, sck=0, sdo=0, and no `frame_done`. After release, a fresh ch0 frame starts correctly.
- `GAP_CYCLES`=0 with a backlog on ch2 and ch3 -> CS high for exactly 2 clks (END, IDLE) between frames.
- With `DAC_SCHED_SIMUL_UPDATE_EN`: ch0=0x0F0 and ch3=0xF00 -> frames 24'h000F00 and 24'h03F000, followed by 24'h1F0000; no further frames follow.
